// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit in the EX stage.
// Multiply is radix-2 shift-add. Divide is restoring, one bit per cycle.
// A normal operation spends 32 cycles in CALC, then one cycle in FINISH.
// Divide-by-zero and signed overflow skip CALC and go straight to FINISH.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      launch request, one cycle while the instruction sits in EX
//   funct3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a       rs1 value (forwarded)
//   op_b       rs2 value (forwarded)
//   flush      pipeline flush of EX; aborts any operation without done
//   busy       operation in progress (CALC or FINISH)
//   stall_req  freeze IF/ID/EX until done (combinational)
//   done       one-cycle pulse; result valid this cycle
//   result     registered operation result, held until the next FINISH
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  stall_req,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W = DATA_WIDTH;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StCalc   = 2'd1;
    localparam logic [1:0] StFinish = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           fn_q, fn_d;
    logic                 neg_q, neg_d;
    // Multiplicand for multiply, divisor for divide.
    logic [W-1:0]         opnd_q, opnd_d;
    // Multiply: {high product, low product/multiplier}. Divide: low half is the quotient.
    logic [2*W-1:0]       acc_q, acc_d;
    logic [W:0]           rem_q, rem_d;
    logic [W-1:0]         result_q, result_d;

    // Operand preparation at accept
    logic         a_signed, b_signed, sign_a, sign_b;
    logic [W-1:0] mag_a, mag_b;
    logic         div_zero, div_ovf, special;
    logic [W-1:0] special_res;
    logic         accept;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sign_a   = a_signed && op_a[W-1];
        sign_b   = b_signed && op_b[W-1];
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;

        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(W-1){1'b0}}}) &&
                   (op_b == '1);
        special  = div_zero || div_ovf;

        if (div_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else begin
            // Signed overflow: quotient is the dividend itself, remainder is zero.
            special_res = funct3[1] ? '0 : op_a;
        end

        accept = start && (state_q == StIdle) && !flush;
    end

    // One iteration of multiply and divide, plus final sign fix-up
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic [W+1:0]   div_diff;
    logic           div_ok;
    logic [W:0]     rem_next;
    logic [W-1:0]   quo_next;
    logic [2*W-1:0] iter_acc;
    logic [W:0]     iter_rem;
    logic [2*W-1:0] mul_fin;
    logic [W-1:0]   quo_fin, rem_lo, rem_fin, calc_res;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[W-1:1]};

        div_shift = {rem_q[W-1:0], acc_q[W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        div_ok    = !div_diff[W+1];
        rem_next  = div_ok ? div_diff[W:0] : div_shift;
        quo_next  = {acc_q[W-2:0], div_ok};

        iter_acc  = fn_q[2] ? {acc_q[2*W-1:W], quo_next} : mul_next;
        iter_rem  = fn_q[2] ? rem_next : rem_q;

        // Final values are taken from the last iteration so result lands in FINISH.
        mul_fin   = neg_q ? -mul_next : mul_next;
        quo_fin   = neg_q ? -quo_next : quo_next;
        rem_lo    = rem_next[W-1:0];
        rem_fin   = neg_q ? -rem_lo : rem_lo;

        if (fn_q[2]) begin
            calc_res = fn_q[1] ? rem_fin : quo_fin;
        end else if (fn_q[1:0] == 2'b00) begin
            calc_res = mul_fin[W-1:0];
        end else begin
            calc_res = mul_fin[2*W-1:W];
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fn_d     = fn_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    fn_d  = funct3;
                    cnt_d = '0;
                    rem_d = '0;
                    if (funct3[2]) begin
                        // DIV: quotient sign; REM: sign of dividend.
                        neg_d  = funct3[1] ? sign_a : (sign_a ^ sign_b);
                        opnd_d = mag_b;
                        acc_d  = {{W{1'b0}}, mag_a};
                    end else begin
                        neg_d  = sign_a ^ sign_b;
                        opnd_d = mag_a;
                        acc_d  = {{W{1'b0}}, mag_b};
                    end
                    if (special) begin
                        result_d = special_res;
                        state_d  = StFinish;
                    end else begin
                        state_d  = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = iter_acc;
                    rem_d = iter_rem;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(W - 1)) begin
                        result_d = calc_res;
                        state_d  = StFinish;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            fn_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fn_q     <= fn_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        stall_req = accept || (state_q == StCalc);
        // A flush in FINISH kills the completion pulse.
        done      = (state_q == StFinish) && !flush;
        result    = result_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: a cycle-level latency model with
// arithmetic reference results, checked every cycle, plus directed vectors.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    ex_muldiv_unit #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .funct3   (funct3),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .busy     (busy),
        .stall_req(stall_req),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference straight from the RV32M definitions.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Latency model: m_left = cycles left including the done cycle (0 = idle).
    int          m_left = 0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_res  <= '0;
            m_pend <= '0;
        end else if (m_left > 0) begin
            if (flush && m_left > 1) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 2) m_res <= m_pend;
            end
        end else if (start && !flush) begin
            m_pend <= ref_op(funct3, op_a, op_b);
            if (is_special(funct3, op_a, op_b)) begin
                m_left <= 1;
                m_res  <= ref_op(funct3, op_a, op_b);
            end else begin
                m_left <= 33;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = (m_left > 1) || (m_left == 0 && start && !flush);
        check("busy",      32'(busy),      32'(m_left > 0));
        check("done",      32'(done),      32'(m_left == 1));
        check("stall_req", 32'(stall_req), 32'(exp_stall));
        check("result",    result,         m_res);
    end

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 15));
            4:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one op, scramble inputs while it runs, and check latency/result/stall.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_lat, input string name,
                          input bit hold);
        int   lat;
        int   stall_cnt;
        int   extra_done;
        logic stall_at_done;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; op_a = a; op_b = b; flush = 1'b0;
        lat = -1; stall_cnt = 0; stall_at_done = 1'b1; extra_done = 0;
        for (int cyc = 0; cyc < 40 && lat < 0; cyc++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc;
                stall_at_done = stall_req;
                check({name, " result"}, result, exp_r);
            end else if (stall_req) begin
                stall_cnt++;
            end
            @(posedge clk); #1;
            start  = hold && (lat < 0);
            op_a   = $urandom;
            op_b   = $urandom;
            funct3 = 3'($urandom_range(0, 7));
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " stall cycles"}, 32'(stall_cnt), 32'(exp_lat));
        check({name, " stall at done"}, 32'(stall_at_done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check({name, " extra done"}, 32'(extra_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; flush = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy",   32'(busy),      32'd0);
        check("reset stall",  32'(stall_req), 32'd0);
        check("reset done",   32'(done),      32'd0);
        check("reset result", result,         32'd0);
        #1 rst_n = 1'b1;

        // Pin the reference model to hand-computed values.
        check("model MUL",    ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("model MULH",   ref_op(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("model MULHSU", ref_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("model MULHU",  ref_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("model DIV",    ref_op(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("model REM",    ref_op(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL 7*-3", 1'b0);
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, "MULH", 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU", 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU", 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "DIV -7/2", 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "REM -7/2", 1'b0);
        run_op(3'd5, 32'd100,        32'd7,         32'd14,        33, "DIVU 100/7", 1'b0);
        run_op(3'd7, 32'd100,        32'd7,         32'd2,         33, "REMU 100/7", 1'b0);
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "DIV ovf", 1'b0);
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  "REM ovf", 1'b0);
        run_op(3'd6, 32'd5,          32'd0,         32'd5,         1,  "REM 5/0", 1'b0);
        run_op(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "DIVU 5/0", 1'b0);

        // Flush in cycle 10 of a DIV: no done, result keeps 0xFFFFFFFF.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush busy",   32'(busy),      32'd0);
        check("flush stall",  32'(stall_req), 32'd0);
        check("flush done",   32'(done),      32'd0);
        check("flush result", result,         32'hFFFF_FFFF);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, "MUL after flush", 1'b0);

        // start held high for the whole op: exactly one done.
        run_op(3'd3, 32'h0001_0000, 32'h0003_0000, 32'd3, 33, "MULHU held start", 1'b1);

        // start together with flush in IDLE is not accepted.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        check("start+flush stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("start+flush busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of CALC.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async rst busy",   32'(busy),      32'd0);
        check("async rst stall",  32'(stall_req), 32'd0);
        check("async rst done",   32'(done),      32'd0);
        check("async rst result", result,         32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        run_op(3'd0, 32'd5, 32'd6, 32'd30, 33, "MUL after reset", 1'b0);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            start  = ($urandom_range(0, 5) == 0);
            funct3 = 3'($urandom_range(0, 7));
            op_a   = rnd_op();
            op_b   = rnd_op();
            flush  = (m_left != 1) && ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
